alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 8-bit ALU between two requesters (execute unit = requester 0, address/branch unit = requester 1). Round-robin arbitration with a lock so a requester can chain ADD→ADC sequences without the other requester corrupting the ALU's carry. Per operation: the block latches the opcode and operands, drives the ALU, and captures the result and flags. It returns them with a one-cycle done pulse.

## Interface
- STARVE_LIMIT, 4: maximum consecutive locked ops by one owner before the lock is forcibly broken (range 1-15).
- i_CLK  in  1  clock; all state changes at posedge.
- i_RST  in  1  asynchronous, active-high reset.
- i_Req0 / i_Req1  in  1  request, sampled only in IDLE.
- i_Lock0 / i_Lock1  in  1  sampled with request; high = keep ownership after this op.
- i_Op0 / i_Op1  in  4  ALU opcode.
- i_A0, i_B0 / i_A1, i_B1  in  8  operands (Data1, Data2).
- o_Gnt0 / o_Gnt1  out  1  high from issue until the done edge.
- o_Done0 / o_Done1  out  1  one-cycle pulse; o_Result and flags valid in this cycle and held until next done.
- o_Result  out  8  captured ALU result.
- o_Z, o_S, o_C, o_OF  out  1  captured ALU flags.
- o_LockBrk  out  1  one-cycle pulse when STARVE_LIMIT breaks a lock.
- o_ALUOp  out  4  to ALU i_ALUOp.
- o_ALUData1, o_ALUData2  out  8  to ALU.
- i_ALUResult  in  8  from ALU o_Result.
- i_ALUZ, i_ALUS, i_ALUC, i_ALUOF  in  1  from ALU flags.

## Operation
- FSM states:
  - IDLE: evaluates requests.
  - EXEC: ALU samples the op this edge.
  - CAPT: ALU outputs settled; the block captures them.
- IDLE → EXEC when an eligible request is present.
  - On this edge: latch op/operands into o_ALUOp/o_ALUData*, set o_GntN, record owner and its lock bit.
- EXEC → CAPT unconditionally.
  - On this edge: o_ALUOp returns to ALUOP_NOP so the ALU holds its result.
- CAPT → IDLE.
  - On this edge: copy i_ALU* into o_Result/flags, clear o_GntN, pulse o_DoneN.
- The done cycle is IDLE. A request held high in the done cycle is a new request; this gives back-to-back chaining.
- Eligibility:
  - If a lock is held, only the owner is eligible.
  - Otherwise both are eligible; on conflict, grant the requester not served last. The round-robin pointer updates on every grant.
- Lock hold: the lock persists while the owner's issued ops have lock high.
- Lock release, any of:
  - owner issues an op with lock low (that op completes normally);
  - owner's request is low in any IDLE cycle;
  - the lock counter reaches STARVE_LIMIT consecutive locked ops. o_LockBrk pulses with that op's done, and the pointer favours the other requester.
- Opcodes pass through unmodified. ALUOP_NOP from a requester is legal: the op completes and the captured values equal the ALU's held values.

## Timing
- Request sampled at edge E0 (IDLE). ALU executes at E1. Capture at E2. o_DoneN high during E2..E3.
- Latency: 3 edges. Max throughput: one op per 3 cycles.
- Operands need only be stable at E0; they may change after o_GntN rises.
- Reset values:
  - state IDLE, o_Gnt*/o_Done*/o_LockBrk = 0;
  - o_Result = 8'h00, all flags 0;
  - o_ALUOp = ALUOP_NOP, o_ALUData* = 8'h00;
  - no lock, lock counter 0, pointer favours requester 0.
- Reset mid-op (EXEC/CAPT): the op is discarded, with no done pulse.
- The ALU is not reset; its carry survives. Requesters must not start a chain with ADC after reset.
- Both requests rising in the same IDLE cycle: exactly one grant, the other is served in the next IDLE cycle if still requested.

## Structure
- Constants.v additions:
  - ALUOP_NOP = the single unassigned 4-bit opcode (the ALU ignores it);
  - FSM state codes ST_IDLE/ST_EXEC/ST_CAPT.
- One sub-module, rr_pick2: combinational two-way picker. Inputs: requests, lock-owner mask, pointer. Output: one-hot grant.
- FSM, lock counter and capture registers live in alu_arbiter.

## Test plan
- Single op: Req0, Op=ADD, A=8'h7F, B=8'h01 → o_Done0 at 3rd edge, o_Result=8'h80, S=1, OF=1, Z=0, C=0.
- Conflict: Req0 and Req1 both high from reset → requester 0 served first, then requester 1. Done pulses 3 cycles apart, never simultaneous.
- Carry chain: Req1 locked ADD 8'hFF+8'h01, then unlocked ADC A=8'h00, with Req0 held high throughout → results 8'h00 (C=1) then 8'h01. Requester 0 is granted only after the ADC.
- Starvation: Req0 locked continuously, STARVE_LIMIT=4, Req1 high → o_LockBrk pulses with the 4th done, then o_Gnt1.
- Reset during EXEC → no done pulse, all outputs at reset values, o_ALUOp=ALUOP_NOP, next request completes normally.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// Opcode map of the 8-bit ALU; 4'hF is the one code the ALU ignores.
package alu_arbiter_pkg;

  localparam logic [3:0] ALUOP_ADD  = 4'h0;
  localparam logic [3:0] ALUOP_ADC  = 4'h1;
  localparam logic [3:0] ALUOP_SUB  = 4'h2;
  localparam logic [3:0] ALUOP_SBB  = 4'h3;
  localparam logic [3:0] ALUOP_AND  = 4'h4;
  localparam logic [3:0] ALUOP_OR   = 4'h5;
  localparam logic [3:0] ALUOP_XOR  = 4'h6;
  localparam logic [3:0] ALUOP_NOT  = 4'h7;
  localparam logic [3:0] ALUOP_SHL  = 4'h8;
  localparam logic [3:0] ALUOP_SHR  = 4'h9;
  localparam logic [3:0] ALUOP_INC  = 4'hA;
  localparam logic [3:0] ALUOP_DEC  = 4'hB;
  localparam logic [3:0] ALUOP_PASA = 4'hC;
  localparam logic [3:0] ALUOP_PASB = 4'hD;
  localparam logic [3:0] ALUOP_NEG  = 4'hE;
  localparam logic [3:0] ALUOP_NOP  = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_req_t;

  function automatic logic [1:0] owner_mask(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_pick.sv
// Combinational two-way picker: eligible = req & mask, ties go to ptr.
module rr_pick2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       ptr,
  output logic [1:0] gnt
);

  logic [1:0] elig;

  assign elig = req & mask;

  always_comb begin
    gnt = 2'b00;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between two requesters with round-robin arbitration
// and a carry-preserving lock that is forcibly broken after STARVE_LIMIT ops.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_Req0,
  input  logic       i_Req1,
  input  logic       i_Lock0,
  input  logic       i_Lock1,
  input  logic [3:0] i_Op0,
  input  logic [3:0] i_Op1,
  input  logic [7:0] i_A0,
  input  logic [7:0] i_B0,
  input  logic [7:0] i_A1,
  input  logic [7:0] i_B1,
  output logic       o_Gnt0,
  output logic       o_Gnt1,
  output logic       o_Done0,
  output logic       o_Done1,
  output logic [7:0] o_Result,
  output logic       o_Z,
  output logic       o_S,
  output logic       o_C,
  output logic       o_OF,
  output logic       o_LockBrk,
  output logic [3:0] o_ALUOp,
  output logic [7:0] o_ALUData1,
  output logic [7:0] o_ALUData2,
  input  logic [7:0] i_ALUResult,
  input  logic       i_ALUZ,
  input  logic       i_ALUS,
  input  logic       i_ALUC,
  input  logic       i_ALUOF
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic       owner;
  logic       locked;
  logic       ptr;
  logic       brk_pend;
  logic [3:0] lock_cnt;

  logic [1:0] req;
  logic [1:0] mask;
  logic [1:0] pick;
  logic       lock_live;
  logic       win;
  logic       win_lock;
  logic [3:0] cnt_next;
  logic       hit_limit;
  alu_req_t   sel;

  assign req = {i_Req1, i_Req0};

  // A lock only counts while its owner is still requesting.
  assign lock_live = locked && (owner ? i_Req1 : i_Req0);
  assign mask      = lock_live ? owner_mask(owner) : 2'b11;

  rr_pick2 u_pick (
    .req  (req),
    .mask (mask),
    .ptr  (ptr),
    .gnt  (pick)
  );

  assign win       = pick[1];
  assign win_lock  = win ? i_Lock1 : i_Lock0;
  assign cnt_next  = (lock_live ? lock_cnt : 4'd0) + 4'd1;
  assign hit_limit = (cnt_next >= LIMIT);
  assign sel       = win ? alu_req_t'{op: i_Op1, a: i_A1, b: i_B1}
                         : alu_req_t'{op: i_Op0, a: i_A0, b: i_B0};

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      locked     <= 1'b0;
      ptr        <= 1'b0;
      brk_pend   <= 1'b0;
      lock_cnt   <= 4'd0;
      o_Gnt0     <= 1'b0;
      o_Gnt1     <= 1'b0;
      o_Done0    <= 1'b0;
      o_Done1    <= 1'b0;
      o_LockBrk  <= 1'b0;
      o_Result   <= 8'h00;
      o_Z        <= 1'b0;
      o_S        <= 1'b0;
      o_C        <= 1'b0;
      o_OF       <= 1'b0;
      o_ALUOp    <= ALUOP_NOP;
      o_ALUData1 <= 8'h00;
      o_ALUData2 <= 8'h00;
    end else begin
      o_Done0   <= 1'b0;
      o_Done1   <= 1'b0;
      o_LockBrk <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (locked && !lock_live) begin
            locked   <= 1'b0;
            lock_cnt <= 4'd0;
          end
          if (|pick) begin
            state      <= ST_EXEC;
            o_ALUOp    <= sel.op;
            o_ALUData1 <= sel.a;
            o_ALUData2 <= sel.b;
            o_Gnt0     <= !win;
            o_Gnt1     <= win;
            owner      <= win;
            ptr        <= !win;
            // The op that reaches the limit still runs; only the lock is dropped.
            if (win_lock && !hit_limit) begin
              locked   <= 1'b1;
              lock_cnt <= cnt_next;
            end else begin
              locked   <= 1'b0;
              lock_cnt <= 4'd0;
            end
            brk_pend <= win_lock && hit_limit;
          end
        end
        ST_EXEC: begin
          o_ALUOp <= ALUOP_NOP;
          state   <= ST_CAPT;
        end
        ST_CAPT: begin
          o_Result  <= i_ALUResult;
          o_Z       <= i_ALUZ;
          o_S       <= i_ALUS;
          o_C       <= i_ALUC;
          o_OF      <= i_ALUOF;
          o_Gnt0    <= 1'b0;
          o_Gnt1    <= 1'b0;
          o_Done0   <= !owner;
          o_Done1   <= owner;
          o_LockBrk <= brk_pend;
          brk_pend  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic scored
// against a transaction-level model of the arbitration and lock rules.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
  logic [3:0] op0 = ALUOP_NOP, op1 = ALUOP_NOP;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic       gnt0, gnt1, done0, done1, lockbrk;
  logic [7:0] result;
  logic       fz, fs, fc, fof;
  logic [3:0] alu_op;
  logic [7:0] d1, d2;

  logic [7:0] alu_res = 8'h00;
  logic       alu_z = 0, alu_s = 0, alu_c = 0, alu_of = 0;

  int n_checks = 0;
  int n_pass   = 0;

  bit         m_locked = 0, m_owner = 0, m_fav = 0;
  int         m_cnt = 0;
  logic [11:0] m_held = 12'h000;

  logic [3:0] rand_ops [6];

  always #5 clk = ~clk;

  alu_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_Req0(req0), .i_Req1(req1), .i_Lock0(lock0), .i_Lock1(lock1),
    .i_Op0(op0), .i_Op1(op1), .i_A0(a0), .i_B0(b0), .i_A1(a1), .i_B1(b1),
    .o_Gnt0(gnt0), .o_Gnt1(gnt1), .o_Done0(done0), .o_Done1(done1),
    .o_Result(result), .o_Z(fz), .o_S(fs), .o_C(fc), .o_OF(fof),
    .o_LockBrk(lockbrk), .o_ALUOp(alu_op), .o_ALUData1(d1), .o_ALUData2(d2),
    .i_ALUResult(alu_res), .i_ALUZ(alu_z), .i_ALUS(alu_s), .i_ALUC(alu_c),
    .i_ALUOF(alu_of)
  );

  // Returns {Z, S, C, OF, result[7:0]}.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, of;
    c  = 1'b0;
    of = 1'b0;
    case (op)
      ALUOP_ADD: w = {1'b0, a} + {1'b0, b};
      ALUOP_ADC: w = {1'b0, a} + {1'b0, b} + {8'h00, cin};
      ALUOP_SUB: w = {1'b0, a} - {1'b0, b};
      ALUOP_AND: w = {1'b0, a & b};
      ALUOP_OR:  w = {1'b0, a | b};
      ALUOP_XOR: w = {1'b0, a ^ b};
      default:   w = {1'b0, a};
    endcase
    r = w[7:0];
    if (op == ALUOP_ADD || op == ALUOP_ADC) begin
      c  = w[8];
      of = (a[7] == b[7]) && (r[7] != a[7]);
    end else if (op == ALUOP_SUB) begin
      c  = w[8];
      of = (a[7] != b[7]) && (r[7] != a[7]);
    end
    return {(r == 8'h00), r[7], c, of, r};
  endfunction

  // ALU stand-in: registered, never reset, holds its outputs on NOP.
  always @(posedge clk) begin
    if (alu_op != ALUOP_NOP)
      {alu_z, alu_s, alu_c, alu_of, alu_res} <= alu_fn(alu_op, d1, d2, alu_c);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {gnt1, gnt0}, 2'b00);
    check({tag, "_done"}, {done1, done0, lockbrk}, 3'b000);
    check({tag, "_result"}, result, 8'h00);
    check({tag, "_flags"}, {fz, fs, fc, fof}, 4'h0);
    check({tag, "_aluop"}, alu_op, ALUOP_NOP);
    check({tag, "_data"}, {d1, d2}, 16'h0000);
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_fav    = 0;
    m_cnt    = 0;
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the done cycle.
  task automatic issue(input bit r0, input bit l0, input logic [3:0] o0, input logic [7:0] x0,
                       input logic [7:0] y0, input bit r1, input bit l1, input logic [3:0] o1,
                       input logic [7:0] x1, input logic [7:0] y1, output bit win);
    bit          brk;
    int          cnt;
    logic [3:0]  op;
    logic [11:0] exp;
    req0 = r0; lock0 = l0; op0 = o0; a0 = x0; b0 = y0;
    req1 = r1; lock1 = l1; op1 = o1; a1 = x1; b1 = y1;

    if (m_locked && !(m_owner ? r1 : r0)) begin
      m_locked = 0;
      m_cnt    = 0;
    end
    if (m_locked)      win = m_owner;
    else if (r0 && r1) win = m_fav;
    else               win = r1;
    m_fav = !win;
    brk   = 0;
    if (win ? l1 : l0) begin
      cnt = (m_locked ? m_cnt : 0) + 1;
      if (cnt >= LIMIT) begin
        brk = 1; m_locked = 0; m_cnt = 0;
      end else begin
        m_locked = 1; m_owner = win; m_cnt = cnt;
      end
    end else begin
      m_locked = 0; m_cnt = 0;
    end
    op  = win ? o1 : o0;
    exp = (op == ALUOP_NOP) ? m_held
        : alu_fn(op, win ? x1 : x0, win ? y1 : y0, m_held[9]);
    m_held = exp;

    @(posedge clk); #1;
    check("gnt0_issue", gnt0, !win);
    check("gnt1_issue", gnt1, win);
    op0 = 4'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
    op1 = 4'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    @(posedge clk); #1;
    check("done_early", {done1, done0}, 2'b00);
    @(posedge clk); #1;
    check("done0", done0, !win);
    check("done1", done1, win);
    check("result", result, exp[7:0]);
    check("flags", {fz, fs, fc, fof}, exp[11:8]);
    check("lockbrk", lockbrk, brk);
    check("gnt_clear", {gnt1, gnt0}, 2'b00);
    $display("txn win=%0d op=%0h result=%02h flags=%04b brk=%0d", win, op, result,
             {fz, fs, fc, fof}, lockbrk);
    @(negedge clk);
  endtask

  initial begin
    bit         w;
    logic [1:0] r;
    rand_ops = '{ALUOP_ADD, ALUOP_ADC, ALUOP_SUB, ALUOP_AND, ALUOP_XOR, ALUOP_NOP};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Simultaneous requests from reset: requester 0 first, then requester 1.
    issue(1, 0, ALUOP_ADD, 8'h11, 8'h22, 1, 0, ALUOP_SUB, 8'h50, 8'h10, w);
    check("conflict_first", w, 1'b0);
    issue(1, 0, ALUOP_ADD, 8'h11, 8'h22, 1, 0, ALUOP_SUB, 8'h50, 8'h10, w);
    check("conflict_second", w, 1'b1);

    issue(1, 0, ALUOP_ADD, 8'h7F, 8'h01, 0, 0, ALUOP_NOP, 8'h00, 8'h00, w);
    check("single_result", result, 8'h80);
    check("single_flags", {fz, fs, fc, fof}, 4'b0101);

    // Carry chain on requester 1 while requester 0 keeps asking.
    issue(1, 0, ALUOP_XOR, 8'h0F, 8'hF0, 1, 1, ALUOP_ADD, 8'hFF, 8'h01, w);
    check("chain_add_owner", w, 1'b1);
    check("chain_add_result", {fc, result}, 9'h100);
    issue(1, 0, ALUOP_XOR, 8'h0F, 8'hF0, 1, 0, ALUOP_ADC, 8'h00, 8'h00, w);
    check("chain_adc_owner", w, 1'b1);
    check("chain_adc_result", result, 8'h01);
    issue(1, 0, ALUOP_AND, 8'h3C, 8'h0F, 0, 0, ALUOP_NOP, 8'h00, 8'h00, w);
    check("chain_then_req0", w, 1'b0);

    // Starvation: requester 0 holds the lock until the limit breaks it.
    issue(1, 1, ALUOP_ADD, 8'h01, 8'h02, 0, 0, ALUOP_SUB, 8'h09, 8'h01, w);
    for (int i = 0; i < LIMIT - 1; i++) begin
      issue(1, 1, ALUOP_ADD, 8'(i), 8'h02, 1, 0, ALUOP_SUB, 8'h09, 8'h01, w);
      check("starve_owner", w, 1'b0);
    end
    check("starve_brk", lockbrk, 1'b1);
    issue(1, 1, ALUOP_ADD, 8'h01, 8'h02, 1, 0, ALUOP_SUB, 8'h09, 8'h01, w);
    check("starve_then_req1", w, 1'b1);
    check("starve_brk_clear", lockbrk, 1'b0);

    // Reset while the op sits in EXEC.
    req0 = 1; lock0 = 1; op0 = ALUOP_ADD; a0 = 8'h40; b0 = 8'h40;
    req1 = 0; lock1 = 0;
    @(posedge clk); #1;
    check("rst_mid_gnt", gnt0, 1'b1);
    @(negedge clk);
    rst  = 1'b1;
    req0 = 0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_mid_no_done", {done1, done0, gnt1, gnt0}, 4'h0);
    end
    @(negedge clk);
    issue(1, 0, ALUOP_SUB, 8'h05, 8'h07, 1, 0, ALUOP_ADD, 8'h01, 8'h01, w);
    check("post_rst_ptr", w, 1'b0);

    for (int t = 0; t < 150; t++) begin
      r = 2'($urandom_range(1, 3));
      issue(r[0], $urandom_range(0, 3) != 0, rand_ops[$urandom_range(0, 5)],
            8'($urandom), 8'($urandom),
            r[1], $urandom_range(0, 3) != 0, rand_ops[$urandom_range(0, 5)],
            8'($urandom), 8'($urandom), w);
    end

    req0 = 0;
    req1 = 0;
    repeat (2) @(posedge clk);
    #1 check("idle_end", {gnt1, gnt0}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
